// File: rtl/ram_pkg.sv
// Shared state encoding and default widths for ram_req_ctrl.
// RAM_REQ_CTRL_CLEAR_EN adds the CLEAR state to the encoding.
package ram_pkg;

  localparam int unsigned RAM_DATA_WIDTH = 8;
  localparam int unsigned RAM_ADDR_WIDTH = 4;

`ifdef RAM_REQ_CTRL_CLEAR_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RDCAP = 3'd3,
    ST_CLEAR = 3'd4
  } ram_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RDCAP = 3'd3
  } ram_state_e;
`endif

endpackage

// File: rtl/ram_req_ctrl.sv
// Request controller for a downstream single-port synchronous RAM.
// Define RAM_REQ_CTRL_CLEAR_EN to enable the clr_start full-memory clear sweep.
module ram_req_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  ram_state_e            state_q, state_d;
  logic                  ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  busy_d;
  logic                  clr_go;

`ifdef RAM_REQ_CTRL_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  assign clr_go = clr_start;

  // Clear sweep address counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign clr_go           = 1'b0;
`endif

  // A pending clear blocks acceptance in the same IDLE cycle
  assign req_ready = ~busy & ~clr_go;

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
`ifdef RAM_REQ_CTRL_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (clr_go) begin
`ifdef RAM_REQ_CTRL_CLEAR_EN
          state_d    = ST_CLEAR;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = '0;
          clr_cnt_d  = '0;
`endif
        end else if (req_valid) begin
          ram_addr_d = req_addr;
          if (req_we) begin
            state_d   = ST_WRITE;
            ram_we_d  = 1'b1;
            ram_din_d = req_wdata;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_RDCAP;
      ST_RDCAP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_dout;
      end
`ifdef RAM_REQ_CTRL_CLEAR_EN
      ST_CLEAR: begin
        // Stop after the top address; no wrap-around write to 0
        if (clr_cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d  = clr_cnt_q + ADDR_WIDTH'(1);
          ram_we_d   = 1'b1;
          ram_addr_d = clr_cnt_q + ADDR_WIDTH'(1);
          ram_din_d  = '0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a behavioural synchronous RAM model.
// Clear tests are compiled when RAM_REQ_CTRL_CLEAR_EN is defined.
module tb_ram_req_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       clr_start, busy;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } vec_t;

  always #5 clk = ~clk;

  ram_req_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clr_start (clr_start),
    .busy      (busy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Single-port RAM: data for an address presented with ram_we=0 appears one clock later
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, pass the acceptance edge, then scramble the fields
  task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d);
    int k;
    k = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    check("ready_wait", 32'(k < 50), 32'd1);
    tick();
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wdata = ~d;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    issue(1'b1, a, d);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'(a));
    check("wr_ram_din", 32'(ram_din), 32'(d));
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("wr_we_drop", 32'(ram_we), 32'd0);
    check("wr_idle", 32'(busy), 32'd0);
  endtask

  // rsp_valid is seen after the second edge following the acceptance edge (3rd edge counting it)
  task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
    issue(1'b0, a, 8'h00);
    check("rd_ram_we", 32'(ram_we), 32'd0);
    check("rd_ram_addr", 32'(ram_addr), 32'(a));
    check("rd_valid_c1", 32'(rsp_valid), 32'd0);
    tick();
    check("rd_valid_c2", 32'(rsp_valid), 32'd0);
    tick();
    check("rd_valid_c3", 32'(rsp_valid), 32'd1);
    check("rd_rdata", 32'(rsp_rdata), 32'(exp));
    tick();
    check("rd_valid_pulse", 32'(rsp_valid), 32'd0);
    check("rd_rdata_hold", 32'(rsp_rdata), 32'(exp));
  endtask

  initial begin
    vec_t vecs[12];
    int n;

    vecs[0]  = '{1'b1, 4'd3,  8'hA5};
    vecs[1]  = '{1'b0, 4'd3,  8'hA5};
    vecs[2]  = '{1'b1, 4'd0,  8'h11};
    vecs[3]  = '{1'b1, 4'd15, 8'hFF};
    vecs[4]  = '{1'b1, 4'd7,  8'h3C};
    vecs[5]  = '{1'b1, 4'd8,  8'hC3};
    vecs[6]  = '{1'b0, 4'd0,  8'h11};
    vecs[7]  = '{1'b0, 4'd15, 8'hFF};
    vecs[8]  = '{1'b0, 4'd7,  8'h3C};
    vecs[9]  = '{1'b0, 4'd8,  8'hC3};
    vecs[10] = '{1'b1, 4'd3,  8'h5A};
    vecs[11] = '{1'b0, 4'd3,  8'h5A};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clr_start = 1'b0;
    repeat (2) tick();

    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    check("ready_after_reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data);
      else            do_read(vecs[i].addr, vecs[i].data);
    end

    // Back-to-back writes with req_valid held high
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd9;
    for (int i = 0; i < 8; i++) begin
      check("b2b_ready", 32'(req_ready), 32'((i % 2) == 0));
      check("b2b_ram_we", 32'(ram_we), 32'((i % 2) == 1));
      if ((i % 2) == 0) req_wdata = 8'(8'h90 + i);
      tick();
    end
    req_valid = 1'b0;
    do_read(4'd9, 8'h96);

    // Reset dropped in the middle of a read
    issue(1'b0, 4'd3, 8'h00);
    check("mid_rd_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rrst_ram_we", 32'(ram_we), 32'd0);
    check("rrst_ram_addr", 32'(ram_addr), 32'd0);
    check("rrst_ram_din", 32'(ram_din), 32'd0);
    check("rrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rrst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("rrst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("rrst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("rrst_idle", 32'(busy), 32'd0);

`ifdef RAM_REQ_CTRL_CLEAR_EN
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'(8'h20 + a));
    clr_start = 1'b1;
    #1;
    check("clr_blocks_ready", 32'(req_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_ram_we", 32'(ram_we), 32'd1);
      check("clr_ram_addr", 32'(ram_addr), 32'(i));
      check("clr_ram_din", 32'(ram_din), 32'd0);
      tick();
    end
    check("clr_done_busy", 32'(busy), 32'd0);
    check("clr_no_wrap_we", 32'(ram_we), 32'd0);
    do_read(4'd15, 8'h00);
    do_read(4'd3, 8'h00);

    // Clear and request together: clear wins, request waits
    clr_start = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd2;
    req_wdata = 8'h42;
    #1;
    check("clr_req_ready", 32'(req_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      check("clr_req_wait", 32'(req_ready), 32'd0);
      tick();
      n++;
    end
    check("clr_req_cycles", 32'(n), 32'd16);
    check("clr_req_ready_after", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("clr_req_we", 32'(ram_we), 32'd1);
    check("clr_req_addr", 32'(ram_addr), 32'd2);
    check("clr_req_din", 32'(ram_din), 32'h42);
    tick();
    do_read(4'd2, 8'h42);
`else
    // Without the clear feature clr_start has no effect
    clr_start = 1'b1;
    #1;
    check("noclr_ready", 32'(req_ready), 32'd1);
    do_read(4'd9, 8'h96);
    check("noclr_idle", 32'(busy), 32'd0);
    check("noclr_we", 32'(ram_we), 32'd0);
    clr_start = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width; memory depth SHALL be 2**ADDR_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate that a request is presented.
REQ-006 req_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 req_we  input  1  SHALL select write (1) or read (0) for the presented request.
REQ-008 req_addr  input  ADDR_WIDTH  SHALL carry the request address.
REQ-009 req_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-010 rsp_valid  output  1  SHALL be a single-cycle pulse marking valid read data.
REQ-011 rsp_rdata  output  DATA_WIDTH  SHALL carry the read data, held until the next response.
REQ-012 clr_start  input  1  SHALL request a full-memory clear sweep; the pulse is sampled in IDLE only.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 ram_we, ram_addr, ram_din  outputs  1/ADDR_WIDTH/DATA_WIDTH  SHALL drive the downstream single-port RAM.
REQ-015 ram_dout  input  DATA_WIDTH  SHALL be RAM read data, valid one clock after the address is presented with ram_we=0.

Function
REQ-016 The FSM SHALL have the states IDLE, WRITE, READ, RDCAP and CLEAR.
REQ-017 req_ready SHALL be high only in IDLE with clr_start low; a request is accepted when req_valid and req_ready are both high.
REQ-018 An accepted write SHALL go IDLE->WRITE, drive ram_we=1, ram_addr and ram_din from the registered request for exactly one cycle, then return to IDLE.
REQ-019 An accepted read SHALL go IDLE->READ (ram_we=0, registered address driven) ->RDCAP, capturing ram_dout into rsp_rdata, pulsing rsp_valid for one cycle, then return to IDLE.
REQ-020 Read latency SHALL be 3 clocks from the acceptance edge to rsp_valid; write occupancy SHALL be 2 clocks; peak throughput SHALL be one request per 2 (write) or 3 (read) clocks.
REQ-021 Request fields SHALL be registered at acceptance; input changes after acceptance SHALL have no effect.
REQ-022 When clr_start and req_valid are both high in IDLE, clr_start SHALL win and the request SHALL wait (req_ready=0).
REQ-023 CLEAR SHALL write 0 to addresses 0 through 2**ADDR_WIDTH-1 in ascending order, one per cycle, using an ADDR_WIDTH-bit counter, then return to IDLE after the last address without a wrap-around write.
REQ-024 Outside WRITE and CLEAR, ram_we SHALL be 0.
REQ-025 req_valid SHALL be ignored while busy is high; no request SHALL be queued.

Reset
REQ-026 Assertion of reset_n low SHALL force IDLE immediately and set ram_we=0, ram_addr=0, ram_din=0, rsp_valid=0, rsp_rdata=0, busy=0 and the clear counter to 0.
REQ-027 Reset in the middle of a read or clear SHALL abandon the operation; no rsp_valid SHALL follow reset release, and the clear SHALL not resume.
REQ-028 req_ready SHALL be high in the first cycle after reset release.

Configuration
REQ-029 Macro RAM_REQ_CTRL_CLEAR_EN: when defined, REQ-012, REQ-022 and REQ-023 SHALL apply.
REQ-030 When RAM_REQ_CTRL_CLEAR_EN is undefined, the CLEAR state and counter SHALL be absent, clr_start SHALL be ignored, and all other behaviour SHALL be unchanged.

Structure
REQ-031 The FSM state encoding typedef and the default widths SHALL live in shared package ram_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the RAM SHALL be instantiated alongside it at the parent level.

Verification
REQ-033 Write 0xA5 to address 3, then read address 3 -> rsp_valid 3 clocks after read acceptance, rsp_rdata=0xA5.
REQ-034 Issue back-to-back writes with req_valid held high -> req_ready pulses every 2nd cycle and ram_we is never high for two consecutive cycles.
REQ-035 With CLEAR_EN, fill the RAM, pulse clr_start -> busy for 16 cycles, ram_addr 0..15, then a read of address 15 returns 0x00.
REQ-036 Assert clr_start and req_valid together -> the clear runs first and the request is accepted in the first IDLE cycle afterwards.
REQ-037 Drop reset_n during READ -> outputs are zero immediately, no rsp_valid after release, and req_ready=1 on the next cycle.
REQ-038 Change req_addr and req_wdata in the cycle after write acceptance -> the RAM receives the originally accepted values.
